// File: rtl/tl_pkg.sv
// Shared TileLink-UL opcodes and lane/beat arithmetic for the width widget.
// Helpers take the port byte widths as arguments so any widget instance can share them.
package tl_pkg;

  typedef enum logic [2:0] {
    PUT_FULL_DATA    = 3'd0,
    PUT_PARTIAL_DATA = 3'd1,
    GET              = 3'd4
  } a_opcode_e;

  typedef enum logic [2:0] {
    ACCESS_ACK      = 3'd0,
    ACCESS_ACK_DATA = 3'd1,
    HINT_ACK        = 3'd2
  } d_opcode_e;

  // A message that covers the whole wide beat always starts at lane 0.
  function automatic int unsigned lane_offset(int unsigned addr_lo, int unsigned size,
                                              int unsigned in_bytes, int unsigned out_bytes);
    if ((32'd1 << size) >= in_bytes) return 0;
    return (addr_lo % in_bytes) / out_bytes;
  endfunction

  function automatic int unsigned beat_count(int unsigned size, int unsigned in_bytes,
                                             int unsigned out_bytes);
    if ((32'd1 << size) >= in_bytes) return in_bytes / out_bytes;
    if ((32'd1 << size) <= out_bytes) return 1;
    return (32'd1 << size) / out_bytes;
  endfunction

endpackage

// File: rtl/tl_width_widget_split_if.sv
// One TileLink-UL port (channels A and D) of a given beat width.
// The master side issues A requests and accepts D responses.
interface tl_width_widget_split_if #(
  parameter int BYTES       = 8,
  parameter int ADDR_BITS   = 31,
  parameter int SOURCE_BITS = 3,
  parameter int SIZE_BITS   = 4
);
  logic                   a_valid;
  logic                   a_ready;
  logic [2:0]             a_opcode;
  logic [2:0]             a_param;
  logic [SIZE_BITS-1:0]   a_size;
  logic [SOURCE_BITS-1:0] a_source;
  logic [ADDR_BITS-1:0]   a_address;
  logic [BYTES-1:0]       a_mask;
  logic [8*BYTES-1:0]     a_data;
  logic                   a_corrupt;

  logic                   d_valid;
  logic                   d_ready;
  logic [2:0]             d_opcode;
  logic [1:0]             d_param;
  logic [SIZE_BITS-1:0]   d_size;
  logic [SOURCE_BITS-1:0] d_source;
  logic                   d_sink;
  logic                   d_denied;
  logic [8*BYTES-1:0]     d_data;
  logic                   d_corrupt;

  modport master (
    output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
    input  a_ready,
    input  d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data, d_corrupt,
    output d_ready
  );

  modport slave (
    input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
    output a_ready,
    output d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data, d_corrupt,
    input  d_ready
  );
endinterface

// File: rtl/tl_width_lane_table.sv
// Per-source lane-offset register file: one write port, one combinational read port.
// Remembers where each outstanding request sat inside the wide beat.
module tl_width_lane_table #(
  parameter int SOURCE_BITS = 3,
  parameter int LANE_BITS   = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   we,
  input  logic [SOURCE_BITS-1:0] waddr,
  input  logic [LANE_BITS-1:0]   wdata,
  input  logic [SOURCE_BITS-1:0] raddr,
  output logic [LANE_BITS-1:0]   rdata
);
  localparam int DEPTH = 1 << SOURCE_BITS;

  logic [LANE_BITS-1:0] mem_q [DEPTH];
  logic [LANE_BITS-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[raddr];
endmodule

// File: rtl/tl_width_widget_split.sv
// TileLink-UL width converter: splits wide A beats into narrow ones and gathers
// narrow AccessAckData beats back into wide D beats.
module tl_width_widget_split
  import tl_pkg::*;
#(
  parameter int IN_BYTES    = 8,
  parameter int OUT_BYTES   = 4,
  parameter int ADDR_BITS   = 31,
  parameter int SOURCE_BITS = 3,
  parameter int SIZE_BITS   = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  tl_width_widget_split_if.slave  auto_in,
  tl_width_widget_split_if.master auto_out
);
  localparam int R         = IN_BYTES / OUT_BYTES;
  localparam int LANE_BITS = $clog2(R);
  localparam int LW        = (LANE_BITS > 0) ? LANE_BITS : 1;
  localparam int OW        = 8 * OUT_BYTES;
  localparam int IW        = 8 * IN_BYTES;
  localparam int LG_OUT    = $clog2(OUT_BYTES);

  logic [ADDR_BITS-1:0] a_addr;
  logic [SIZE_BITS-1:0] a_size;
  logic [SIZE_BITS-1:0] d_size;
  logic                 a_is_put, a_at_last, a_fire, tbl_we;
  logic [LW-1:0]        a_cnt_q, a_cnt_d, a_off, a_last, a_lane;

  logic                 d_has_data, d_at_last, d_fire;
  logic [LW-1:0]        d_cnt_q, d_cnt_d, d_base, d_last, d_lane;
  logic                 denied_q, denied_d, corrupt_q, corrupt_d;
  logic [IW-1:0]        d_buf_q, d_buf_d, d_merged;

  assign a_addr = auto_in.a_address;
  assign a_size = auto_in.a_size;
  assign d_size = auto_out.d_size;

  // A splitter: a_cnt counts slices relative to the request's starting lane.
  always_comb begin
    a_is_put  = (auto_in.a_opcode == PUT_FULL_DATA) || (auto_in.a_opcode == PUT_PARTIAL_DATA);
    a_off     = LW'(lane_offset(32'(a_addr), 32'(a_size), IN_BYTES, OUT_BYTES));
    a_last    = a_is_put ? LW'(beat_count(32'(a_size), IN_BYTES, OUT_BYTES) - 1) : '0;
    a_lane    = a_off + a_cnt_q;
    a_at_last = (a_cnt_q == a_last);
    a_fire    = auto_out.a_valid && auto_out.a_ready;
    tbl_we    = a_fire && (a_cnt_q == '0);
    a_cnt_d   = a_cnt_q;
    if (a_fire) a_cnt_d = a_at_last ? '0 : a_cnt_q + LW'(1);
  end

  assign auto_out.a_valid   = auto_in.a_valid && !reset;
  assign auto_in.a_ready    = auto_out.a_ready && a_at_last && !reset;
  assign auto_out.a_opcode  = auto_in.a_opcode;
  assign auto_out.a_param   = auto_in.a_param;
  assign auto_out.a_size    = auto_in.a_size;
  assign auto_out.a_source  = auto_in.a_source;
  assign auto_out.a_address = auto_in.a_address;
  assign auto_out.a_corrupt = auto_in.a_corrupt;
  assign auto_out.a_data    = auto_in.a_data[OW*int'(a_lane) +: OW];
  assign auto_out.a_mask    = (!a_is_put && (32'(a_size) >= 32'(LG_OUT))) ? '1 :
                              auto_in.a_mask[OUT_BYTES*int'(a_lane) +: OUT_BYTES];

  tl_width_lane_table #(
    .SOURCE_BITS(SOURCE_BITS),
    .LANE_BITS  (LW)
  ) u_lane_table (
    .clock(clock),
    .reset(reset),
    .we   (tbl_we),
    .waddr(auto_in.a_source),
    .wdata(a_off),
    .raddr(auto_out.d_source),
    .rdata(d_base)
  );

  // D merger: earlier beats are absorbed into d_buf; the final beat merges on the fly.
  always_comb begin
    d_has_data = (auto_out.d_opcode == ACCESS_ACK_DATA);
    d_last     = d_has_data ? LW'(beat_count(32'(d_size), IN_BYTES, OUT_BYTES) - 1) : '0;
    d_at_last  = (d_cnt_q == d_last);
    d_lane     = d_base + d_cnt_q;
    d_merged   = d_buf_q;
    d_merged[OW*int'(d_lane) +: OW] = auto_out.d_data;
    d_fire     = auto_out.d_valid && auto_out.d_ready;
    d_cnt_d    = d_cnt_q;
    denied_d   = denied_q;
    corrupt_d  = corrupt_q;
    d_buf_d    = d_buf_q;
    if (d_fire) begin
      if (d_at_last) begin
        d_cnt_d   = '0;
        denied_d  = 1'b0;
        corrupt_d = 1'b0;
      end else begin
        d_cnt_d   = d_cnt_q + LW'(1);
        denied_d  = denied_q || auto_out.d_denied;
        corrupt_d = corrupt_q || auto_out.d_corrupt;
        d_buf_d   = d_merged;
      end
    end
  end

  assign auto_in.d_valid   = auto_out.d_valid && d_at_last && !reset;
  assign auto_out.d_ready  = !reset && (d_at_last ? auto_in.d_ready : 1'b1);
  assign auto_in.d_opcode  = auto_out.d_opcode;
  assign auto_in.d_param   = auto_out.d_param;
  assign auto_in.d_size    = auto_out.d_size;
  assign auto_in.d_source  = auto_out.d_source;
  assign auto_in.d_sink    = auto_out.d_sink;
  assign auto_in.d_denied  = auto_out.d_denied || denied_q;
  assign auto_in.d_corrupt = auto_out.d_corrupt || corrupt_q;
  assign auto_in.d_data    = (d_has_data || R == 1) ? d_merged : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      a_cnt_q   <= '0;
      d_cnt_q   <= '0;
      denied_q  <= 1'b0;
      corrupt_q <= 1'b0;
    end else begin
      a_cnt_q   <= a_cnt_d;
      d_cnt_q   <= d_cnt_d;
      denied_q  <= denied_d;
      corrupt_q <= corrupt_d;
    end
  end

  // Staging buffer carries no state across messages, so it is left unreset.
  always_ff @(posedge clock) d_buf_q <= d_buf_d;
endmodule

// File: tb/tb_tl_width_widget_split.sv
// Directed bench for the 8-to-4 byte width widget; expected beats are queued
// when stimulus is driven and checked as the DUT emits them.
module tb_tl_width_widget_split;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  mask;
    logic [30:0] addr;
  } a_exp_t;

  typedef struct {
    logic [63:0] data;
    logic [63:0] cmp;
    logic        denied;
    logic [2:0]  opcode;
    logic [2:0]  source;
  } d_exp_t;

  a_exp_t exp_a[$];
  d_exp_t exp_d[$];
  int vectors = 0;
  int miscompares = 0;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  tl_width_widget_split_if #(.BYTES(8), .ADDR_BITS(31), .SOURCE_BITS(3), .SIZE_BITS(4)) in_if ();
  tl_width_widget_split_if #(.BYTES(4), .ADDR_BITS(31), .SOURCE_BITS(3), .SIZE_BITS(4)) out_if ();

  tl_width_widget_split #(
    .IN_BYTES(8), .OUT_BYTES(4), .ADDR_BITS(31), .SOURCE_BITS(3), .SIZE_BITS(4)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .auto_in (in_if),
    .auto_out(out_if)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!reset && out_if.a_valid && out_if.a_ready) begin
      if (exp_a.size() == 0) begin
        chk("a_unexpected_beat", 64'(exp_a.size()), 64'd1);
      end else begin
        a_exp_t e;
        e = exp_a.pop_front();
        chk("a_data", 64'(out_if.a_data), 64'(e.data));
        chk("a_mask", 64'(out_if.a_mask), 64'(e.mask));
        chk("a_addr", 64'(out_if.a_address), 64'(e.addr));
      end
    end
  end

  always @(negedge clock) begin
    if (!reset && in_if.d_valid && in_if.d_ready) begin
      if (exp_d.size() == 0) begin
        chk("d_unexpected_beat", 64'(exp_d.size()), 64'd1);
      end else begin
        d_exp_t e;
        e = exp_d.pop_front();
        chk("d_data", in_if.d_data & e.cmp, e.data & e.cmp);
        chk("d_denied", 64'(in_if.d_denied), 64'(e.denied));
        chk("d_corrupt", 64'(in_if.d_corrupt), 64'd0);
        chk("d_opcode", 64'(in_if.d_opcode), 64'(e.opcode));
        chk("d_source", 64'(in_if.d_source), 64'(e.source));
      end
    end
  end

  task automatic send_a(input logic [2:0] op, input logic [3:0] sz, input logic [2:0] src,
                        input logic [30:0] addr, input logic [7:0] mask, input logic [63:0] data,
                        input int n_exp, input int stall);
    int fires = 0;
    int stall_left = 0;
    bit stalled = 0;
    bit done = 0;
    logic [31:0] held = '0;
    in_if.a_valid = 1'b1;   in_if.a_opcode = op;   in_if.a_param = 3'd0;
    in_if.a_size = sz;      in_if.a_source = src;  in_if.a_address = addr;
    in_if.a_mask = mask;    in_if.a_data = data;   in_if.a_corrupt = 1'b0;
    out_if.a_ready = 1'b1;
    for (int c = 0; c < 30 && !done; c++) begin
      @(negedge clock);
      if (out_if.a_valid && out_if.a_ready) fires++;
      if (in_if.a_ready) begin
        chk("in_a_ready_on_last_slice", 64'(fires), 64'(n_exp));
        done = 1;
      end else if (!out_if.a_ready) begin
        chk("a_data_held_in_stall", 64'(out_if.a_data), 64'(held));
      end
      @(posedge clock); #1;
      if (stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) out_if.a_ready = 1'b1;
      end else if (fires == 1 && stall > 0 && !stalled) begin
        stalled = 1;
        stall_left = stall;
        out_if.a_ready = 1'b0;
        held = out_if.a_data;
      end
    end
    chk("a_done", 64'(done), 64'd1);
    in_if.a_valid = 1'b0;
  endtask

  task automatic send_d(input logic [2:0] op, input logic [3:0] sz, input logic [2:0] src,
                        input logic [31:0] data, input logic denied, input bit final_beat,
                        input int hold);
    int hold_left = hold;
    bit done = 0;
    out_if.d_valid = 1'b1;  out_if.d_opcode = op;  out_if.d_param = 2'd0;
    out_if.d_size = sz;     out_if.d_source = src; out_if.d_sink = 1'b0;
    out_if.d_denied = denied; out_if.d_data = data; out_if.d_corrupt = 1'b0;
    in_if.d_ready = (hold == 0);
    for (int c = 0; c < 30 && !done; c++) begin
      @(negedge clock);
      if (out_if.d_ready) begin
        chk("d_inner_valid", 64'(in_if.d_valid), 64'(final_beat));
        done = 1;
      end else begin
        chk("d_stall_valid", 64'(in_if.d_valid), 64'd1);
        if (exp_d.size() > 0) chk("d_stall_data", in_if.d_data, exp_d[0].data);
      end
      @(posedge clock); #1;
      if (hold_left > 0) begin
        hold_left--;
        if (hold_left == 0) in_if.d_ready = 1'b1;
      end
    end
    chk("d_done", 64'(done), 64'd1);
    out_if.d_valid = 1'b0;
  endtask

  initial begin
    bit got;
    in_if.a_valid = 1'b1;   in_if.a_opcode = 3'd0;  in_if.a_param = 3'd0;
    in_if.a_size = 4'd3;    in_if.a_source = 3'd0;  in_if.a_address = 31'h0;
    in_if.a_mask = 8'hFF;   in_if.a_data = 64'h0;   in_if.a_corrupt = 1'b0;
    in_if.d_ready = 1'b1;
    out_if.a_ready = 1'b1;
    out_if.d_valid = 1'b1;  out_if.d_opcode = 3'd1; out_if.d_param = 2'd0;
    out_if.d_size = 4'd3;   out_if.d_source = 3'd0; out_if.d_sink = 1'b0;
    out_if.d_denied = 1'b0; out_if.d_data = 32'h0;  out_if.d_corrupt = 1'b0;

    repeat (2) @(negedge clock);
    chk("rst_out_a_valid", 64'(out_if.a_valid), 64'd0);
    chk("rst_in_a_ready", 64'(in_if.a_ready), 64'd0);
    chk("rst_in_d_valid", 64'(in_if.d_valid), 64'd0);
    chk("rst_out_d_ready", 64'(out_if.d_ready), 64'd0);
    in_if.a_valid = 1'b0;
    out_if.d_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;

    // Full-width PutFull splits low lane first.
    exp_a.push_back('{32'h55667788, 4'hF, 31'h100});
    exp_a.push_back('{32'h11223344, 4'hF, 31'h100});
    send_a(3'd0, 4'd3, 3'd0, 31'h100, 8'hFF, 64'h1122334455667788, 2, 0);

    // Narrow PutFull in the upper lane is a single beat.
    exp_a.push_back('{32'hAABBCCDD, 4'hF, 31'h104});
    send_a(3'd0, 4'd2, 3'd0, 31'h104, 8'hF0, 64'hAABBCCDD_00000000, 1, 0);

    // PutPartial keeps per-lane masks.
    exp_a.push_back('{32'hDDEEFF00, 4'hF, 31'h180});
    exp_a.push_back('{32'h99AABBCC, 4'h0, 31'h180});
    send_a(3'd1, 4'd3, 3'd0, 31'h180, 8'h0F, 64'h99AABBCC_DDEEFF00, 2, 0);

    // Full-width Get then two-beat AccessAckData gather.
    exp_a.push_back('{32'h0, 4'hF, 31'h100});
    send_a(3'd4, 4'd3, 3'd5, 31'h100, 8'hFF, 64'h0, 1, 0);
    exp_d.push_back('{64'hDEAD0000_0000BEEF, 64'hFFFFFFFF_FFFFFFFF, 1'b0, 3'd1, 3'd5});
    send_d(3'd1, 4'd3, 3'd5, 32'h0000BEEF, 1'b0, 1'b0, 0);
    send_d(3'd1, 4'd3, 3'd5, 32'hDEAD0000, 1'b0, 1'b1, 0);

    // Narrow Get on the upper lane returns in data[63:32].
    exp_a.push_back('{32'h0, 4'hF, 31'h10C});
    send_a(3'd4, 4'd2, 3'd2, 31'h10C, 8'hFF, 64'h0, 1, 0);
    exp_d.push_back('{64'h12345678_00000000, 64'hFFFFFFFF_00000000, 1'b0, 3'd1, 3'd2});
    send_d(3'd1, 4'd2, 3'd2, 32'h12345678, 1'b0, 1'b1, 0);

    // A stall mid-split.
    exp_a.push_back('{32'h12345678, 4'hF, 31'h300});
    exp_a.push_back('{32'hCAFEF00D, 4'hF, 31'h300});
    send_a(3'd0, 4'd3, 3'd1, 31'h300, 8'hFF, 64'hCAFEF00D_12345678, 2, 3);

    // Get, then D with denied on the last beat and inner backpressure.
    exp_a.push_back('{32'h0, 4'hF, 31'h300});
    send_a(3'd4, 4'd3, 3'd3, 31'h300, 8'hFF, 64'h0, 1, 0);
    exp_d.push_back('{64'h02020202_01010101, 64'hFFFFFFFF_FFFFFFFF, 1'b1, 3'd1, 3'd3});
    send_d(3'd1, 4'd3, 3'd3, 32'h01010101, 1'b0, 1'b0, 0);
    send_d(3'd1, 4'd3, 3'd3, 32'h02020202, 1'b1, 1'b1, 3);

    // Sticky denied clears; AccessAck carries no data.
    exp_d.push_back('{64'h0, 64'hFFFFFFFF_FFFFFFFF, 1'b0, 3'd0, 3'd3});
    send_d(3'd0, 4'd3, 3'd3, 32'hFFFFFFFF, 1'b0, 1'b1, 0);

    // Denied on the first beat only must still reach the inner beat.
    exp_d.push_back('{64'h04040404_03030303, 64'hFFFFFFFF_FFFFFFFF, 1'b1, 3'd1, 3'd3});
    send_d(3'd1, 4'd3, 3'd3, 32'h03030303, 1'b1, 1'b0, 0);
    send_d(3'd1, 4'd3, 3'd3, 32'h04040404, 1'b0, 1'b1, 0);

    // Reset after the first slice discards the burst.
    exp_a.push_back('{32'h11111111, 4'hF, 31'h200});
    in_if.a_valid = 1'b1;   in_if.a_opcode = 3'd0;  in_if.a_size = 4'd3;
    in_if.a_source = 3'd4;  in_if.a_address = 31'h200;
    in_if.a_mask = 8'hFF;   in_if.a_data = 64'h22222222_11111111;
    out_if.a_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clock);
      if (out_if.a_valid && out_if.a_ready) got = 1;
    end
    chk("rst_mid_first_fire", 64'(got), 64'd1);
    @(posedge clock); #1;
    reset = 1'b1;
    in_if.a_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    exp_a.push_back('{32'h66666666, 4'hF, 31'h100});
    exp_a.push_back('{32'h77777777, 4'hF, 31'h100});
    send_a(3'd0, 4'd3, 3'd0, 31'h100, 8'hFF, 64'h77777777_66666666, 2, 0);

    repeat (3) @(posedge clock);
    chk("a_queue_drained", 64'(exp_a.size()), 64'd0);
    chk("d_queue_drained", 64'(exp_d.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
